// File: rtl/lstm_feeder_pkg.sv
// Shared definitions for the lstm_feeder initiator: widths, gate indices,
// core latency and FSM state encodings.
package lstm_feeder_pkg;
    localparam int FP8_W        = 8;
    localparam int FP16_W       = 16;
    localparam int SD8_W        = 8;
    localparam int NUM_GATES    = 4;
    localparam int CORE_LATENCY = 7;

    localparam logic [1:0] GATE_F = 2'd0;
    localparam logic [1:0] GATE_I = 2'd1;
    localparam logic [1:0] GATE_G = 2'd2;
    localparam logic [1:0] GATE_O = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;
endpackage

// File: rtl/lstm_feeder_fifo.sv
// x_t input FIFO for lstm_feeder: DEPTH x WIDTH, first-word-fall-through
// read port, full/empty flags, asynchronous active-low reset.
module lstm_feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; a push while full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/lstm_feeder.sv
// lstm_feeder: initiator for the lstm_top core. Buffers x_t, holds per-gate
// FloatSD8 weights / FP16 biases, issues one timestep at a time, returns h_out
// to the host and feeds h_out/c_next back as h_prev/c_prev.
// Optional feature: define LSTM_FEEDER_TIMEOUT_EN to enable the core-ready
// watchdog (sticky err, step dropped after TIMEOUT_CYCLES in WAIT).
module lstm_feeder
    import lstm_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int H_SHIFT        = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_gate,
    input  logic [SD8_W-1:0]  cfg_w,
    input  logic [FP16_W-1:0] cfg_b,
    output logic              cfg_ready,
    input  logic [15:0]       seq_len,
    input  logic              x_valid,
    input  logic [FP8_W-1:0]  x_data,
    output logic              x_ready,
    output logic              core_start,
    output logic [FP8_W-1:0]  core_x,
    output logic [FP8_W-1:0]  core_hprev,
    output logic [FP16_W-1:0] core_cprev,
    output logic [SD8_W-1:0]  core_w,
    output logic [FP16_W-1:0] core_bias,
    input  logic              core_ready,
    input  logic [FP16_W-1:0] core_h,
    input  logic [FP16_W-1:0] core_c,
    output logic              h_valid,
    output logic [FP16_W-1:0] h_data,
    output logic              h_last,
    input  logic              h_ready,
    output logic              err
);
    state_t                   state;
    logic [1:0]               g;
    logic [SD8_W-1:0]         w_reg [NUM_GATES];
    logic [FP16_W-1:0]        b_reg [NUM_GATES];
    logic [15:0]              step;
    logic [15:0]              len;
    logic [15:0]              seq_len_eff;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic [FP8_W-1:0]         fifo_dout;
    logic                     start_issue;
    logic                     last_step;
    logic [SD8_W-1:0]         w0_fwd;
    logic [FP16_W-1:0]        b0_fwd;
    logic signed [FP16_W-1:0] h_shifted;

`ifdef LSTM_FEEDER_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;
    logic        err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Clamp a signed 16-bit value into the FP8 h_prev range [-128, 127].
    function automatic logic [FP8_W-1:0] sat8(input logic signed [FP16_W-1:0] v);
        if (v > 16'sd127)       return 8'h7F;
        else if (v < -16'sd128) return 8'h80;
        else                    return v[FP8_W-1:0];
    endfunction

    lstm_feeder_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FP8_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (x_data),
        .pop   (start_issue),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cfg_ready   = (state == ST_IDLE);
    assign x_ready     = !fifo_full;
    assign fifo_push   = x_valid && !fifo_full;
    assign start_issue = !fifo_empty && ((state == ST_IDLE) || ((state == ST_OUT) && h_ready));
    assign last_step   = (step == len - 16'd1);
    assign seq_len_eff = (seq_len == 16'd0) ? 16'd1 : seq_len;
    assign h_shifted   = $signed(core_h) >>> H_SHIFT;

    // A gate-F write landing in the same cycle IDLE exits must reach the first ISSUE beat.
    assign w0_fwd = (cfg_wr && cfg_ready && (cfg_gate == GATE_F)) ? cfg_w : w_reg[GATE_F];
    assign b0_fwd = (cfg_wr && cfg_ready && (cfg_gate == GATE_F)) ? cfg_b : b_reg[GATE_F];

    // Per-gate weight/bias registers, writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GATES; i++) begin
                w_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else if (cfg_wr && cfg_ready) begin
            w_reg[cfg_gate] <= cfg_w;
            b_reg[cfg_gate] <= cfg_b;
        end
    end

    // Timestep sequencer: issue gate schedule, wait for core, hand result to host.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            g          <= GATE_F;
            step       <= '0;
            len        <= '0;
            core_start <= 1'b0;
            core_x     <= '0;
            core_hprev <= '0;
            core_cprev <= '0;
            core_w     <= '0;
            core_bias  <= '0;
            h_valid    <= 1'b0;
            h_data     <= '0;
            h_last     <= 1'b0;
`ifdef LSTM_FEEDER_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            case (state)
                ST_ISSUE: begin
                    // seq_len is captured on the first beat of a sequence's first step
                    if ((g == GATE_F) && (step == 16'd0)) len <= seq_len_eff;
                    if (g == GATE_O) begin
                        state     <= ST_WAIT;
                        core_w    <= '0;
                        core_bias <= '0;
`ifdef LSTM_FEEDER_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end else begin
                        g         <= g + 2'd1;
                        core_w    <= w_reg[g + 2'd1];
                        core_bias <= b_reg[g + 2'd1];
                    end
                end
                ST_WAIT: begin
                    if (core_ready) begin
                        state      <= ST_OUT;
                        h_valid    <= 1'b1;
                        h_data     <= core_h;
                        h_last     <= last_step;
                        core_cprev <= core_c;
                        core_hprev <= sat8(h_shifted);
                    end
`ifdef LSTM_FEEDER_TIMEOUT_EN
                    else if (wait_cnt == TO_LIMIT) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                ST_OUT: begin
                    if (h_ready) begin
                        h_valid <= 1'b0;
                        h_last  <= 1'b0;
                        state   <= ST_IDLE;
                        if (h_last) begin
                            step       <= '0;
                            core_hprev <= '0;
                            core_cprev <= '0;
                        end else begin
                            step <= step + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
            // Entering ISSUE (from IDLE or straight from OUT) presents gate F and pops x_t.
            if (start_issue) begin
                state      <= ST_ISSUE;
                g          <= GATE_F;
                core_start <= 1'b1;
                core_x     <= fifo_dout;
                core_w     <= w0_fwd;
                core_bias  <= b0_fwd;
            end
        end
    end
endmodule

// File: tb/tb_lstm_feeder.sv
// Scoreboard bench for lstm_feeder: stimulus queues the expected core
// transactions and host results; a core model and a host monitor pop and compare.
module tb_lstm_feeder;
    import lstm_feeder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr;
    logic [1:0]  cfg_gate;
    logic [7:0]  cfg_w;
    logic [15:0] cfg_b;
    logic        cfg_ready;
    logic [15:0] seq_len;
    logic        x_valid;
    logic [7:0]  x_data;
    logic        x_ready;
    logic        core_start;
    logic [7:0]  core_x;
    logic [7:0]  core_hprev;
    logic [15:0] core_cprev;
    logic [7:0]  core_w;
    logic [15:0] core_bias;
    logic        core_ready;
    logic [15:0] core_h;
    logic [15:0] core_c;
    logic        h_valid;
    logic [15:0] h_data;
    logic        h_last;
    logic        h_ready;
    logic        err;

    lstm_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr(cfg_wr), .cfg_gate(cfg_gate), .cfg_w(cfg_w), .cfg_b(cfg_b), .cfg_ready(cfg_ready),
        .seq_len(seq_len), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
        .core_start(core_start), .core_x(core_x), .core_hprev(core_hprev), .core_cprev(core_cprev),
        .core_w(core_w), .core_bias(core_bias), .core_ready(core_ready), .core_h(core_h), .core_c(core_c),
        .h_valid(h_valid), .h_data(h_data), .h_last(h_last), .h_ready(h_ready), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  x;
        logic [15:0] rh;
        logic [15:0] rc;
        logic [7:0]  hp_in;
        logic [15:0] cp_in;
    } txn_t;

    typedef struct {
        logic [15:0] h;
        logic [7:0]  hp;
        logic [15:0] cp;
        logic        last;
    } res_t;

    txn_t       txq[$];
    res_t       sb[$];
    logic [7:0]  wr [4];
    logic [15:0] br [4];
    logic        core_mute = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    // Core model: checks the issued schedule and answers CORE_LATENCY cycles after start.
    initial begin : core_model
        txn_t t;
        core_ready = 1'b0;
        core_h     = '0;
        core_c     = '0;
        forever begin
            @(negedge clk);
            if (core_start && !core_mute) begin
                if (txq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL core_start_unexpected: got start, required none");
                end else begin
                    t = txq.pop_front();
                    check("core_hprev_in", 32'(core_hprev), 32'(t.hp_in));
                    check("core_cprev_in", 32'(core_cprev), 32'(t.cp_in));
                    for (int gi = 0; gi < NUM_GATES; gi++) begin
                        if (gi != 0) @(negedge clk);
                        check("core_start_beat", 32'(core_start), 32'(gi == 0));
                        check("core_w", 32'(core_w), 32'(wr[gi]));
                        check("core_bias", 32'(core_bias), 32'(br[gi]));
                        check("core_x_issue", 32'(core_x), 32'(t.x));
                    end
                    repeat (CORE_LATENCY - NUM_GATES + 1) @(negedge clk);
                    check("core_x_held", 32'(core_x), 32'(t.x));
                    check("core_w_idle", 32'(core_w), 32'h0);
                    core_h     = t.rh;
                    core_c     = t.rc;
                    core_ready = 1'b1;
                    @(negedge clk);
                    core_ready = 1'b0;
                end
            end
        end
    end

    // Host monitor: pops the scoreboard on every accepted result.
    initial begin : host_monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && h_valid && h_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL h_valid_unexpected: got h_data %0h, required no result", h_data);
                end else begin
                    e = sb.pop_front();
                    check("h_data", 32'(h_data), 32'(e.h));
                    check("h_last", 32'(h_last), 32'(e.last));
                    check("hprev_fb", 32'(core_hprev), 32'(e.hp));
                    check("cprev_fb", 32'(core_cprev), 32'(e.cp));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic cfg_write(input logic [1:0] gate, input logic [7:0] w, input logic [15:0] b);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_gate = gate; cfg_w = w; cfg_b = b;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic push_x(input logic [7:0] x);
        int n = 0;
        @(negedge clk);
        while (!x_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!x_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got x_ready 0, required 1");
        end else begin
            x_valid = 1'b1;
            x_data  = x;
            @(negedge clk);
            x_valid = 1'b0;
        end
    endtask

    task automatic expect_step(input logic [7:0] x, input logic [15:0] rh, input logic [15:0] rc,
                               input logic [7:0] hp_in, input logic [15:0] cp_in,
                               input logic [7:0] hp_out, input logic last);
        txn_t t;
        res_t r;
        t.x = x; t.rh = rh; t.rc = rc; t.hp_in = hp_in; t.cp_in = cp_in;
        r.h = rh; r.hp = hp_out; r.cp = rc; r.last = last;
        txq.push_back(t);
        sb.push_back(r);
        push_x(x);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || txq.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || txq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sb.size());
            sb.delete();
            txq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!core_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!core_start) begin
            checks++;
            errors++;
            $display("FAIL %s_start_timeout: got core_start 0, required 1", name);
        end
    endtask

    initial begin : stimulus
        int n;
        rst_n = 1'b0; cfg_wr = 1'b0; cfg_gate = '0; cfg_w = '0; cfg_b = '0;
        seq_len = 16'd1; x_valid = 1'b0; x_data = '0; h_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state: datapath outputs cleared, idle and FIFO empty.
        check("rst_core_start", 32'(core_start), 32'h0);
        check("rst_core_x", 32'(core_x), 32'h0);
        check("rst_core_w", 32'(core_w), 32'h0);
        check("rst_core_bias", 32'(core_bias), 32'h0);
        check("rst_core_hprev", 32'(core_hprev), 32'h0);
        check("rst_core_cprev", 32'(core_cprev), 32'h0);
        check("rst_h_valid", 32'(h_valid), 32'h0);
        check("rst_h_data", 32'(h_data), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'h1);
        check("rst_x_ready", 32'(x_ready), 32'h1);
        rst_n = 1'b1;

        wr = '{8'h21, 8'h22, 8'h23, 8'h24};
        br = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        for (int i = 0; i < 4; i++) cfg_write(2'(i), wr[i], br[i]);

        // Single-step sequence.
        seq_len = 16'd1;
        expect_step(8'h05, 16'h0300, 16'h1234, 8'h00, 16'h0000, 8'h30, 1'b1);
        drain("single");

        // Three steps with saturating feedback; first step sees cleared feedback.
        seq_len = 16'd3;
        expect_step(8'h11, 16'h0900, 16'h0001, 8'h00, 16'h0000, 8'h7F, 1'b0);
        expect_step(8'h12, 16'hF000, 16'h0002, 8'h7F, 16'h0001, 8'h80, 1'b0);
        expect_step(8'h13, 16'h0300, 16'h0003, 8'h80, 16'h0002, 8'h30, 1'b1);
        drain("seq3");

        // seq_len of zero behaves as one.
        seq_len = 16'd0;
        expect_step(8'h31, 16'h0000, 16'h0000, 8'h00, 16'h0000, 8'h00, 1'b1);
        drain("len0");

        // Host back-pressure with a full FIFO; cfg write while busy is ignored.
        seq_len = 16'd5;
        h_ready = 1'b0;
        expect_step(8'h21, 16'h0100, 16'h0A01, 8'h00, 16'h0000, 8'h10, 1'b0);
        expect_step(8'h22, 16'h0200, 16'h0A02, 8'h10, 16'h0A01, 8'h20, 1'b0);
        expect_step(8'h23, 16'h0450, 16'h0A03, 8'h20, 16'h0A02, 8'h45, 1'b0);
        expect_step(8'h24, 16'hFF80, 16'h0A04, 8'h45, 16'h0A03, 8'hF8, 1'b0);
        expect_step(8'h25, 16'h07F0, 16'h0A05, 8'hF8, 16'h0A04, 8'h7F, 1'b1);
        n = 0;
        while (!h_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_h_valid_seen", 32'(h_valid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) begin
                cfg_wr = 1'b1; cfg_gate = 2'd0; cfg_w = 8'hEE; cfg_b = 16'hBEEF;
            end
            if (i == 3) cfg_wr = 1'b0;
            check("bp_h_valid", 32'(h_valid), 32'h1);
            check("bp_h_data", 32'(h_data), 32'h0100);
            check("bp_x_ready", 32'(x_ready), 32'h0);
            check("bp_no_start", 32'(core_start), 32'h0);
            check("bp_cfg_ready", 32'(cfg_ready), 32'h0);
        end
        @(posedge clk);
        #1 h_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_start", 32'(core_start), 32'h1);
        drain("backpressure");

`ifdef LSTM_FEEDER_TIMEOUT_EN
        // Core never answers: watchdog drops the step after TIMEOUT_CYCLES in WAIT.
        core_mute = 1'b1;
        seq_len   = 16'd1;
        push_x(8'h41);
        wait_start("timeout");
        repeat (CORE_LATENCY + 28) @(negedge clk);
        check("to_err_early", 32'(err), 32'h0);
        @(negedge clk);
        check("to_err", 32'(err), 32'h1);
        check("to_idle", 32'(cfg_ready), 32'h1);
        check("to_no_h_valid", 32'(h_valid), 32'h0);
        repeat (3) @(negedge clk);
`endif

        // Asynchronous reset in the middle of ISSUE.
        core_mute = 1'b1;
        seq_len   = 16'd1;
        push_x(8'h51);
        wait_start("rst_mid");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_core_start", 32'(core_start), 32'h0);
        check("rmid_core_x", 32'(core_x), 32'h0);
        check("rmid_core_w", 32'(core_w), 32'h0);
        check("rmid_core_bias", 32'(core_bias), 32'h0);
        check("rmid_core_hprev", 32'(core_hprev), 32'h0);
        check("rmid_h_valid", 32'(h_valid), 32'h0);
        check("rmid_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rmid_no_result", 32'(h_valid), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
